shift_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one logical left/right shifter between two requesters. Each requester presents operand `a`, shift amount `b` and a direction over a valid/ready handshake. The block grants one requester, captures its operands, performs the shift into a result register and holds the tagged response until the consumer accepts it. It sits between the binary-logic shifter datapath and the two issue ports that use it.

---
 rtl/shift_arbiter_if.sv | 37 +++
 rtl/shift_arbiter.sv | 103 ++++++++++
 tb/tb_shift_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if: request/response bundle for shift_arbiter.
// master = requesters + consumer, slave = arbiter.
interface shift_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_dir;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_dir;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_result;
  logic             resp_id;
  logic             busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_dir,
    output req1_valid, req1_a, req1_b, req1_dir,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_result, resp_id, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_dir,
    input  req1_valid, req1_a, req1_b, req1_dir,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_result, resp_id, busy
  );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin share of one logical shifter by two requesters.
// Ports: clk, rst_n (async low), bus (shift_arbiter_if.slave).
module shift_arbiter #(
  parameter int WIDTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  shift_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam int WB = WIDTH + 1;
  localparam logic [WB-1:0] W_LIM = WB'(WIDTH);

  state_t           state;
  logic             last_grant;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_dir;
  logic             op_id;
  logic [WIDTH-1:0] result_q;
  logic             resp_valid_q;
  logic             resp_id_q;
  logic             busy_q;

  logic             idle;
  logic             gnt0;
  logic             gnt1;
  logic             grant;
  logic [WIDTH-1:0] shift_val;

  // rst_n gates ready so nothing is offered while reset is held
  assign idle  = (state == IDLE) && rst_n;
  assign gnt0  = idle && bus.req0_valid &&
                 (!bus.req1_valid || last_grant);
  assign gnt1  = idle && bus.req1_valid &&
                 (!bus.req0_valid || !last_grant);
  assign grant = gnt0 || gnt1;

  assign bus.req0_ready  = gnt0;
  assign bus.req1_ready  = gnt1;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = result_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.busy        = busy_q;

  always_comb begin
    shift_val = '0;
    if ({1'b0, op_b} < W_LIM) begin
      shift_val = op_dir ? (op_a >> op_b)
                         : (op_a << op_b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      op_a         <= '0;
      op_b         <= '0;
      op_dir       <= 1'b0;
      op_id        <= 1'b0;
      result_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            op_a       <= gnt1 ? bus.req1_a : bus.req0_a;
            op_b       <= gnt1 ? bus.req1_b : bus.req0_b;
            op_dir     <= gnt1 ? bus.req1_dir : bus.req0_dir;
            op_id      <= gnt1;
            last_grant <= gnt1;
            busy_q     <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          result_q     <= shift_val;
          resp_id_q    <= op_id;
          resp_valid_q <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed vectors plus multi-cycle corner sequences.
// Checks arbitration, shift results, backpressure and reset.
module tb_shift_arbiter;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  shift_arbiter_if #(.WIDTH(4)) bus ();

  shift_arbiter #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic [3:0] a;
    logic [3:0] b;
    logic       dir;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    if (v.id) begin
      bus.req1_valid = 1'b1;
      bus.req1_a     = v.a;
      bus.req1_b     = v.b;
      bus.req1_dir   = v.dir;
    end else begin
      bus.req0_valid = 1'b1;
      bus.req0_a     = v.a;
      bus.req0_b     = v.b;
      bus.req0_dir   = v.dir;
    end
    #1;
    chk("ready_win",
        {7'd0, v.id ? bus.req1_ready : bus.req0_ready}, 8'd1);
    chk("ready_lose",
        {7'd0, v.id ? bus.req0_ready : bus.req1_ready}, 8'd0);
    @(posedge clk); #1;
    idle_inputs();
    chk("exec_busy", {7'd0, bus.busy}, 8'd1);
    chk("exec_rv", {7'd0, bus.resp_valid}, 8'd0);
    @(posedge clk); #1;
    chk("resp_rv", {7'd0, bus.resp_valid}, 8'd1);
    chk("resp_result", {4'd0, bus.resp_result}, {4'd0, v.exp});
    chk("resp_id", {7'd0, bus.resp_id}, {7'd0, v.id});
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("accept_rv", {7'd0, bus.resp_valid}, 8'd0);
    chk("accept_busy", {7'd0, bus.busy}, 8'd0);
  endtask

  initial begin
    logic       gseq [4];
    logic       rid  [4];
    logic [3:0] rres [4];
    int         ng;
    int         nr;

    errors = 0;
    checks = 0;

    vecs[0]  = '{1'b0, 4'b1101, 4'b0010, 1'b0, 4'b0100};
    vecs[1]  = '{1'b1, 4'b1101, 4'b0010, 1'b1, 4'b0011};
    vecs[2]  = '{1'b0, 4'b1001, 4'b0001, 1'b0, 4'b0010};
    vecs[3]  = '{1'b1, 4'b1001, 4'b0001, 1'b1, 4'b0100};
    vecs[4]  = '{1'b0, 4'b1111, 4'b0100, 1'b0, 4'b0000};
    vecs[5]  = '{1'b1, 4'b1111, 4'b0100, 1'b1, 4'b0000};
    vecs[6]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000};
    vecs[7]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000};
    vecs[8]  = '{1'b0, 4'b1011, 4'b0011, 1'b0, 4'b1000};
    vecs[9]  = '{1'b1, 4'b1011, 4'b0011, 1'b1, 4'b0001};
    vecs[10] = '{1'b0, 4'b1011, 4'b0000, 1'b1, 4'b1011};

    // reset held with both valids high: no ready offered
    rst_n          = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_a     = 4'd0;
    bus.req0_b     = 4'd0;
    bus.req0_dir   = 1'b0;
    bus.req1_a     = 4'd0;
    bus.req1_b     = 4'd0;
    bus.req1_dir   = 1'b0;
    bus.resp_ready = 1'b0;
    #3;
    chk("rst_ready0", {7'd0, bus.req0_ready}, 8'd0);
    chk("rst_ready1", {7'd0, bus.req1_ready}, 8'd0);
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("idle_rv", {7'd0, bus.resp_valid}, 8'd0);
    chk("idle_result", {4'd0, bus.resp_result}, 8'd0);
    chk("idle_id", {7'd0, bus.resp_id}, 8'd0);
    chk("idle_busy", {7'd0, bus.busy}, 8'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i]);
    end

    // alternation from reset with both valid held
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.req0_valid = 1'b1;
    bus.req0_a     = 4'b0001;
    bus.req0_b     = 4'b0001;
    bus.req0_dir   = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_a     = 4'b1000;
    bus.req1_b     = 4'b0001;
    bus.req1_dir   = 1'b1;
    bus.resp_ready = 1'b1;
    #1;
    ng = 0;
    nr = 0;
    for (int c = 0; c < 30 && nr < 4; c++) begin
      chk("double_ready",
          {7'd0, bus.req0_ready & bus.req1_ready}, 8'd0);
      if (bus.req0_ready || bus.req1_ready) begin
        if (ng < 4) gseq[ng] = bus.req1_ready;
        ng++;
      end
      if (bus.resp_valid) begin
        if (nr < 4) begin
          rid[nr]  = bus.resp_id;
          rres[nr] = bus.resp_result;
        end
        nr++;
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("alt_resp_count", nr[7:0], 8'd4);
    chk("alt_grant_count", ng[7:0], 8'd4);
    for (int i = 0; i < 4; i++) begin
      chk("alt_grant", {7'd0, gseq[i]}, {7'd0, i[0]});
      chk("alt_id", {7'd0, rid[i]}, {7'd0, i[0]});
      chk("alt_result", {4'd0, rres[i]},
          i[0] ? 8'b0100 : 8'b0010);
    end

    // backpressure with requester 1 pending
    bus.req0_valid = 1'b1;
    bus.req0_a     = 4'b0011;
    bus.req0_b     = 4'b0001;
    bus.req0_dir   = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_a     = 4'b0110;
    bus.req1_b     = 4'b0010;
    bus.req1_dir   = 1'b1;
    #1;
    chk("bp_ready0", {7'd0, bus.req0_ready}, 8'd1);
    chk("bp_ready1", {7'd0, bus.req1_ready}, 8'd0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    #1;
    chk("bp_exec_ready1", {7'd0, bus.req1_ready}, 8'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rv", {7'd0, bus.resp_valid}, 8'd1);
      chk("bp_result", {4'd0, bus.resp_result}, 8'b0110);
      chk("bp_id", {7'd0, bus.resp_id}, 8'd0);
      chk("bp_stall0", {7'd0, bus.req0_ready}, 8'd0);
      chk("bp_stall1", {7'd0, bus.req1_ready}, 8'd0);
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    #1;
    chk("bp_hold_ready1", {7'd0, bus.req1_ready}, 8'd0);
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("bp_accept_rv", {7'd0, bus.resp_valid}, 8'd0);
    chk("bp_pending_ready1", {7'd0, bus.req1_ready}, 8'd1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp2_result", {4'd0, bus.resp_result}, 8'b0001);
    chk("bp2_id", {7'd0, bus.resp_id}, 8'd1);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;

    // reset during RESP after a grant to requester 0
    bus.req0_valid = 1'b1;
    bus.req0_a     = 4'b0101;
    bus.req0_b     = 4'b0001;
    bus.req0_dir   = 1'b0;
    #1;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_rv", {7'd0, bus.resp_valid}, 8'd1);
    chk("pre_rst_result", {4'd0, bus.resp_result}, 8'b1010);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rv", {7'd0, bus.resp_valid}, 8'd0);
    chk("mid_rst_busy", {7'd0, bus.busy}, 8'd0);
    chk("mid_rst_result", {4'd0, bus.resp_result}, 8'd0);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("mid_rst_ready0", {7'd0, bus.req0_ready}, 8'd0);
    chk("mid_rst_ready1", {7'd0, bus.req1_ready}, 8'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_tie0", {7'd0, bus.req0_ready}, 8'd1);
    chk("post_rst_tie1", {7'd0, bus.req1_ready}, 8'd0);
    idle_inputs();
    #1;
    @(posedge clk); #1;
    chk("post_rst_rv", {7'd0, bus.resp_valid}, 8'd0);
    chk("post_rst_busy", {7'd0, bus.busy}, 8'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
